// File: rtl/brg_hcc_pkg.sv
// Shared widths and helpers for the HCC multi-port adapter and its arbiter.
package brg_hcc_pkg;

    localparam int reg_id_width_lp   = 5;
    localparam int pkt_type_width_lp = 2;

    // A single channel still needs a 1-bit id so vectors never collapse to zero width.
    function automatic int ch_id_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/brg_hcc_rr_arb.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner on advance.
module brg_hcc_rr_arb
    import brg_hcc_pkg::*;
#(
    parameter int num_ch_p = 2,
    localparam int id_w_lp = ch_id_width(num_ch_p)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic [num_ch_p-1:0] req_i,
    input  logic                advance_i,
    output logic [num_ch_p-1:0] grant_o,
    output logic                v_o
);

    logic [id_w_lp-1:0] ptr_q;
    logic [id_w_lp-1:0] ptr_next;
    logic [id_w_lp-1:0] grant_id;
    logic               found;

    // First pass covers [ptr, n-1]; the second pass wraps to the lowest requester.
    always_comb begin
        grant_o  = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int i = 0; i < num_ch_p; i++) begin
            if (!found && req_i[i] && (i >= int'(ptr_q))) begin
                found       = 1'b1;
                grant_o[i]  = 1'b1;
                grant_id    = id_w_lp'(i);
            end
        end
        for (int i = 0; i < num_ch_p; i++) begin
            if (!found && req_i[i]) begin
                found       = 1'b1;
                grant_o[i]  = 1'b1;
                grant_id    = id_w_lp'(i);
            end
        end
    end

    assign v_o = found;

    always_comb begin
        ptr_next = '0;
        if (grant_id != id_w_lp'(num_ch_p - 1)) begin
            ptr_next = grant_id + id_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else if (advance_i && found) begin
            ptr_q <= ptr_next;
        end
    end

endmodule

// File: rtl/brg_hcc_multi_port_adapter.sv
// Merges per-channel accelerator requests onto one manycore endpoint with per-channel
// credit limits, and routes returned responses back to the channel encoded in reg_id.
module brg_hcc_multi_port_adapter
    import brg_hcc_pkg::*;
#(
    parameter int num_ch_p       = 2,
    // No sensible default exists; integrators always set this to the endpoint packet width.
    parameter int packet_width_p = 64,
    parameter int data_width_p   = 32,
    parameter int ch_credits_p   = 8,
    localparam int ch_id_w_lp    = ch_id_width(num_ch_p),
    localparam int cnt_w_lp      = $clog2(ch_credits_p + 1)
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,

    input  logic [num_ch_p-1:0]                req_v_i,
    input  logic [num_ch_p*packet_width_p-1:0] req_packet_i,
    output logic [num_ch_p-1:0]                req_ready_o,

    output logic                               out_v_o,
    output logic [packet_width_p-1:0]          out_packet_o,
    input  logic                               out_ready_i,

    input  logic                               returned_v_i,
    input  logic [data_width_p-1:0]            returned_data_i,
    input  logic [reg_id_width_lp-1:0]         returned_reg_id_i,
    input  logic [pkt_type_width_lp-1:0]       returned_pkt_type_i,
    output logic                               returned_yumi_o,

    output logic [num_ch_p-1:0]                rsp_v_o,
    output logic [data_width_p-1:0]            rsp_data_o,
    output logic [reg_id_width_lp-1:0]         rsp_reg_id_o,
    output logic [pkt_type_width_lp-1:0]       rsp_pkt_type_o,
    input  logic [num_ch_p-1:0]                rsp_ready_i,

    output logic                               err_o
);

    logic [num_ch_p-1:0]       eligible;
    logic [num_ch_p-1:0]       grant;
    logic                      grant_v;
    logic                      load_en;
    logic                      load;
    logic [packet_width_p-1:0] sel_packet;

    logic                      out_v_q;
    logic [packet_width_p-1:0] out_packet_q;

    logic [cnt_w_lp-1:0]       outstanding_q [num_ch_p];
    logic [num_ch_p-1:0]       cnt_inc;
    logic [num_ch_p-1:0]       cnt_dec;
    logic [num_ch_p-1:0]       cnt_zero;

    logic [ch_id_w_lp-1:0]     rsp_ch;
    logic                      rsp_in_range;
    logic                      rsp_ch_ready;
    logic [num_ch_p-1:0]       deliver;
    logic                      err_set;
    logic                      err_q;

    always_comb begin
        eligible = '0;
        cnt_zero = '0;
        for (int i = 0; i < num_ch_p; i++) begin
            eligible[i] = req_v_i[i] && (outstanding_q[i] < cnt_w_lp'(ch_credits_p));
            cnt_zero[i] = (outstanding_q[i] == '0);
        end
    end

    brg_hcc_rr_arb #(
        .num_ch_p (num_ch_p)
    ) u_arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .req_i     (eligible),
        .advance_i (load),
        .grant_o   (grant),
        .v_o       (grant_v)
    );

    // The register refills in the same cycle it drains, sustaining one packet per cycle.
    assign load_en     = !out_v_q || out_ready_i;
    assign load        = reset_n_i && load_en && grant_v;
    assign req_ready_o = load ? grant : '0;

    always_comb begin
        sel_packet = '0;
        for (int i = 0; i < num_ch_p; i++) begin
            if (grant[i]) begin
                sel_packet = req_packet_i[i*packet_width_p +: packet_width_p];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_v_q <= 1'b0;
        end else if (load_en) begin
            out_v_q <= grant_v;
        end
    end

    // Payload carries no reset; out_v_o qualifies it.
    always_ff @(posedge clk_i) begin
        if (load) begin
            out_packet_q <= sel_packet;
        end
    end

    assign out_v_o      = out_v_q;
    assign out_packet_o = out_packet_q;

    generate
        if (num_ch_p > 1) begin : g_multi_ch
            assign rsp_ch = returned_reg_id_i[reg_id_width_lp-1 -: ch_id_w_lp];
        end else begin : g_single_ch
            assign rsp_ch = '0;
        end
    endgenerate

    assign rsp_in_range = (int'(rsp_ch) < num_ch_p);

    always_comb begin
        rsp_v_o      = '0;
        deliver      = '0;
        rsp_ch_ready = 1'b0;
        for (int i = 0; i < num_ch_p; i++) begin
            if (rsp_ch == ch_id_w_lp'(i)) begin
                rsp_v_o[i]   = returned_v_i;
                rsp_ch_ready = rsp_ready_i[i];
                deliver[i]   = returned_v_i && rsp_ready_i[i];
            end
        end
    end

    // Responses for nonexistent channels are consumed at once so the network never stalls.
    assign returned_yumi_o = returned_v_i && (rsp_in_range ? rsp_ch_ready : 1'b1);
    assign rsp_data_o      = returned_data_i;
    assign rsp_reg_id_o    = returned_reg_id_i;
    assign rsp_pkt_type_o  = returned_pkt_type_i;

    assign cnt_inc = req_ready_o;
    assign cnt_dec = deliver & ~cnt_zero;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_ch_p; i++) begin
                outstanding_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < num_ch_p; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) begin
                    outstanding_q[i] <= outstanding_q[i] + cnt_w_lp'(1);
                end else if (cnt_dec[i] && !cnt_inc[i]) begin
                    outstanding_q[i] <= outstanding_q[i] - cnt_w_lp'(1);
                end
            end
        end
    end

    // Unsolicited responses and out-of-range channels are protocol errors.
    assign err_set = (returned_v_i && !rsp_in_range) || |(deliver & cnt_zero);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_brg_hcc_multi_port_adapter.sv
// Scoreboard bench: a 4-channel adapter for arbitration/credits/backpressure/reset and a
// 3-channel adapter for the out-of-range response path.
module tb_brg_hcc_multi_port_adapter;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b1;

    logic [3:0]  req_v = '0;
    logic [63:0] req_packet = '0;
    logic [3:0]  req_ready;
    logic        out_v;
    logic [15:0] out_packet;
    logic        out_ready = 1'b1;
    logic        returned_v = 1'b0;
    logic [31:0] returned_data = '0;
    logic [4:0]  returned_reg_id = '0;
    logic [1:0]  returned_pkt_type = '0;
    logic        yumi;
    logic [3:0]  rsp_v;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_reg_id;
    logic [1:0]  rsp_pkt_type;
    logic [3:0]  rsp_ready = '0;
    logic        err;

    logic [2:0]  req_v_b = '0;
    logic [47:0] req_packet_b = '0;
    logic [2:0]  req_ready_b;
    logic        out_v_b;
    logic [15:0] out_packet_b;
    logic        out_ready_b = 1'b1;
    logic        returned_v_b = 1'b0;
    logic        yumi_b;
    logic [2:0]  rsp_v_b;
    logic [31:0] rsp_data_b;
    logic [4:0]  rsp_reg_id_b;
    logic [1:0]  rsp_pkt_type_b;
    logic [2:0]  rsp_ready_b = 3'b111;
    logic        err_b;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  seq = '0;
    logic [15:0] sbq[$];
    logic [15:0] p0;

    always #5 clk_i = ~clk_i;

    brg_hcc_multi_port_adapter #(
        .num_ch_p(4), .packet_width_p(16), .data_width_p(32), .ch_credits_p(2)
    ) dut (
        .clk_i(clk_i), .reset_n_i(rst_n),
        .req_v_i(req_v), .req_packet_i(req_packet), .req_ready_o(req_ready),
        .out_v_o(out_v), .out_packet_o(out_packet), .out_ready_i(out_ready),
        .returned_v_i(returned_v), .returned_data_i(returned_data),
        .returned_reg_id_i(returned_reg_id), .returned_pkt_type_i(returned_pkt_type),
        .returned_yumi_o(yumi),
        .rsp_v_o(rsp_v), .rsp_data_o(rsp_data), .rsp_reg_id_o(rsp_reg_id),
        .rsp_pkt_type_o(rsp_pkt_type), .rsp_ready_i(rsp_ready),
        .err_o(err)
    );

    brg_hcc_multi_port_adapter #(
        .num_ch_p(3), .packet_width_p(16), .data_width_p(32), .ch_credits_p(2)
    ) dut_b (
        .clk_i(clk_i), .reset_n_i(rst_n),
        .req_v_i(req_v_b), .req_packet_i(req_packet_b), .req_ready_o(req_ready_b),
        .out_v_o(out_v_b), .out_packet_o(out_packet_b), .out_ready_i(out_ready_b),
        .returned_v_i(returned_v_b), .returned_data_i(returned_data),
        .returned_reg_id_i(returned_reg_id), .returned_pkt_type_i(returned_pkt_type),
        .returned_yumi_o(yumi_b),
        .rsp_v_o(rsp_v_b), .rsp_data_o(rsp_data_b), .rsp_reg_id_o(rsp_reg_id_b),
        .rsp_pkt_type_o(rsp_pkt_type_b), .rsp_ready_i(rsp_ready_b),
        .err_o(err_b)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] pkt(input int ch);
        return {4'(ch), 4'hA, seq};
    endfunction

    task automatic drive_pkts();
        seq = seq + 8'd1;
        for (int i = 0; i < 4; i++) req_packet[i*16 +: 16] = pkt(i);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        drive_pkts();
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        #1;
        rst_n        = 1'b0;
        req_v        = '0;
        out_ready    = 1'b1;
        returned_v   = 1'b0;
        returned_v_b = 1'b0;
        rsp_ready    = '0;
        sbq.delete();
        #1;
        chk("rst_out_v", 64'(out_v), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_err_b", 64'(err_b), 64'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_n = 1'b1;
    endtask

    // Output side of the scoreboard: every drained packet must match the oldest expected one.
    always @(negedge clk_i) begin
        if (rst_n && out_v === 1'b1 && out_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_out", 64'(out_packet), 64'hFFFF_FFFF);
            end else begin
                chk("sb_out_packet", 64'(out_packet), 64'(sbq.pop_front()));
            end
        end
    end

    initial begin
        #2;
        do_reset();

        // round-robin with all channels requesting
        for (int k = 0; k < 5; k++) begin
            tick();
            req_v = 4'hF;
            settle();
            chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            chk("rr_out_v", 64'(out_v), (k > 0) ? 64'd1 : 64'd0);
            sbq.push_back(pkt(k % 4));
        end
        tick(); req_v = '0; settle();
        chk("rr_last_out_v", 64'(out_v), 64'd1);
        tick(); settle();
        chk("rr_idle_out_v", 64'(out_v), 64'd0);

        // credit limit on channel 1, response held then released
        do_reset();
        for (int k = 0; k < 2; k++) begin
            tick(); req_v = 4'b0010; settle();
            chk("cr_accept", 64'(req_ready), 64'(4'b0010));
            sbq.push_back(pkt(1));
        end
        tick(); settle();
        chk("cr_blocked", 64'(req_ready), 64'd0);
        tick();
        returned_v = 1'b1; returned_reg_id = 5'b01000;
        returned_data = 32'hDEAD_0001; returned_pkt_type = 2'b10; rsp_ready = 4'b0000;
        settle();
        chk("rsp_v_held", 64'(rsp_v), 64'(4'b0010));
        chk("rsp_yumi_held", 64'(yumi), 64'd0);
        chk("rsp_data", 64'(rsp_data), 64'hDEAD_0001);
        chk("rsp_reg_id", 64'(rsp_reg_id), 64'(5'b01000));
        chk("rsp_pkt_type", 64'(rsp_pkt_type), 64'(2'b10));
        chk("cr_still_blocked", 64'(req_ready), 64'd0);
        tick(); settle();
        chk("rsp_yumi_held2", 64'(yumi), 64'd0);
        chk("cr_blocked_held", 64'(req_ready), 64'd0);
        tick(); rsp_ready = 4'b0010; settle();
        chk("rsp_yumi_go", 64'(yumi), 64'd1);
        chk("cr_same_cycle", 64'(req_ready), 64'd0);
        tick(); returned_v = 1'b0; rsp_ready = '0; settle();
        chk("cr_reaccept", 64'(req_ready), 64'(4'b0010));
        chk("rsp_v_idle", 64'(rsp_v), 64'd0);
        sbq.push_back(pkt(1));
        tick(); settle();
        chk("cr_full_again", 64'(req_ready), 64'd0);
        tick(); req_v = '0; settle();
        chk("cr_err_clean", 64'(err), 64'd0);

        // unsolicited response: delivered, flagged, counter stays at zero
        do_reset();
        tick();
        returned_v = 1'b1; returned_reg_id = 5'b10000; rsp_ready = 4'b0100;
        settle();
        chk("uf_rsp_v", 64'(rsp_v), 64'(4'b0100));
        chk("uf_yumi", 64'(yumi), 64'd1);
        chk("uf_err_pre", 64'(err), 64'd0);
        tick(); returned_v = 1'b0; rsp_ready = '0; req_v = 4'b0100; settle();
        chk("uf_err_set", 64'(err), 64'd1);
        chk("uf_accept1", 64'(req_ready), 64'(4'b0100));
        sbq.push_back(pkt(2));
        tick(); settle();
        chk("uf_accept2", 64'(req_ready), 64'(4'b0100));
        sbq.push_back(pkt(2));
        tick(); settle();
        chk("uf_no_underflow", 64'(req_ready), 64'd0);
        tick(); req_v = '0;
        repeat (3) tick();
        settle();
        chk("uf_err_sticky", 64'(err), 64'd1);

        // out-of-range channel on the 3-channel adapter
        chk("oor_err_pre", 64'(err_b), 64'd0);
        tick();
        returned_v_b = 1'b1; returned_reg_id = 5'b11000; returned_data = 32'h1234_5678;
        returned_pkt_type = 2'b01;
        settle();
        chk("oor_yumi", 64'(yumi_b), 64'd1);
        chk("oor_rsp_v", 64'(rsp_v_b), 64'd0);
        chk("oor_err_same", 64'(err_b), 64'd0);
        chk("oor_data", 64'(rsp_data_b), 64'h1234_5678);
        chk("oor_reg_id", 64'(rsp_reg_id_b), 64'(5'b11000));
        chk("oor_pkt_type", 64'(rsp_pkt_type_b), 64'(2'b01));
        chk("oor_no_out", 64'(out_v_b), 64'd0);
        chk("oor_no_ready", 64'(req_ready_b), 64'd0);
        tick(); returned_v_b = 1'b0; settle();
        chk("oor_err_set", 64'(err_b), 64'd1);
        repeat (3) tick();
        settle();
        chk("oor_err_held", 64'(err_b), 64'd1);

        // backpressure: held packet stable, then drain and reload together
        do_reset();
        tick(); req_v = 4'b0001; settle();
        chk("bp_load", 64'(req_ready), 64'(4'b0001));
        p0 = pkt(0);
        sbq.push_back(p0);
        for (int k = 0; k < 5; k++) begin
            tick(); out_ready = 1'b0; settle();
            chk("bp_out_v", 64'(out_v), 64'd1);
            chk("bp_stable", 64'(out_packet), 64'(p0));
            chk("bp_no_ready", 64'(req_ready), 64'd0);
        end
        tick(); out_ready = 1'b1; settle();
        chk("bp_drain_load", 64'(req_ready), 64'(4'b0001));
        sbq.push_back(pkt(0));
        tick(); req_v = '0; settle();
        tick(); settle();

        // reset asserted while a packet is held
        tick(); req_v = 4'b0100; out_ready = 1'b0; settle();
        chk("ar_load", 64'(req_ready), 64'(4'b0100));
        sbq.push_back(pkt(2));
        @(posedge clk_i);
        #1;
        chk("ar_pre_out_v", 64'(out_v), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_async_clear", 64'(out_v), 64'd0);
        sbq.delete();
        settle();
        chk("ar_no_accept", 64'(req_ready), 64'd0);
        @(posedge clk_i);
        #1;
        rst_n = 1'b1; out_ready = 1'b1; req_v = 4'b0100;
        drive_pkts();
        settle();
        chk("ar_first_accept", 64'(req_ready), 64'(4'b0100));
        sbq.push_back(pkt(2));
        @(posedge clk_i);
        #1;
        chk("ar_out_v", 64'(out_v), 64'd1);
        req_v = '0;
        settle();
        tick(); settle();

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/brg_hcc_multi_port_adapter.md
BRG_HCC_MULTI_PORT_ADAPTER -- requirements
Module: brg_hcc_multi_port_adapter

Interface
REQ-001 SHALL have parameter num_ch_p, default 2: number of accelerator request/response channels, 1..8.
REQ-002 SHALL have parameter packet_width_p, default "inv": manycore request packet width.
REQ-003 SHALL have parameter data_width_p, default 32: response data width.
REQ-004 SHALL have parameter ch_credits_p, default 8: maximum outstanding requests per channel.
REQ-005 SHALL have port clk_i, input, 1: the single clock.
REQ-006 SHALL have port reset_n_i, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port req_v_i, input, num_ch_p: per-channel request valid.
REQ-008 SHALL have port req_packet_i, input, num_ch_p*packet_width_p: per-channel packets, channel i in slice i.
REQ-009 SHALL have port req_ready_o, output, num_ch_p: per-channel request accept.
REQ-010 SHALL have port out_v_o, input/output pair: out_v_o output 1, out_packet_o output packet_width_p, out_ready_i input 1 (endpoint credit_or_ready).
REQ-011 SHALL have ports returned_v_i 1, returned_data_i data_width_p, returned_reg_id_i 5, returned_pkt_type_i 2 (inputs) and returned_yumi_o 1 (output).
REQ-012 SHALL have ports rsp_v_o num_ch_p, rsp_data_o data_width_p, rsp_reg_id_o 5, rsp_pkt_type_o 2 (outputs) and rsp_ready_i num_ch_p (input).
REQ-013 SHALL have port err_o, output, 1: sticky protocol-error flag.

Function
REQ-014 SHALL hold one output register (packet + valid); out_v_o and out_packet_o driven only from it; request-to-out_v_o latency one cycle.
REQ-015 Register SHALL load when empty or draining this cycle (out_v_o & out_ready_i); drain and load in one cycle sustain one packet per cycle.
REQ-016 Eligible channel: req_v_i[i] high and outstanding[i] < ch_credits_p.
REQ-017 Arbitration SHALL be round-robin among eligible channels, starting search at pointer; pointer SHALL move to (granted+1) mod num_ch_p only on load.
REQ-018 req_ready_o SHALL be one-hot or zero, asserted only for the granted channel in a load cycle.
REQ-019 outstanding[i] (width clog2(ch_credits_p+1)) SHALL increment on load from channel i, decrement on response delivery to i; both same cycle leaves it unchanged.
REQ-020 Response channel = returned_reg_id_i[4 -: clog2(num_ch_p)] (0 when num_ch_p=1).
REQ-021 Response path SHALL be combinational: rsp_v_o[ch]=returned_v_i, data/reg_id/pkt_type broadcast, returned_yumi_o = returned_v_i & rsp_ready_i[ch].
REQ-022 Channel index >= num_ch_p: SHALL yumi immediately, assert no rsp_v_o, set err_o.
REQ-023 Response to channel with outstanding 0: SHALL deliver, set err_o, counter stays 0 (no underflow).
REQ-024 Output register content SHALL stay stable while out_v_o high and out_ready_i low.
REQ-025 err_o SHALL remain set until reset.

Reset
REQ-026 On reset_n_i low, asynchronously: out_v_o=0, all outstanding=0, pointer=0, err_o=0; out_packet_o value don't-care.
REQ-027 Assertion mid-transfer SHALL discard the held packet; no request accepted while reset_n_i low; first load possible in first cycle after deassertion.

Structure
REQ-028 brg_hcc_pkg SHALL hold reg_id width (5), pkt_type width (2) and channel-id-width function.
REQ-029 Round-robin arbiter SHALL be sub-module brg_hcc_rr_arb (num_ch_p-wide request, grant, advance input).

Verification
REQ-030 num_ch_p=4, all req_v_i high, out_ready_i high: grants 0,1,2,3,0 on consecutive cycles, out_v_o from cycle 1.
REQ-031 ch_credits_p=2, channel 1 only, no responses: two accepts then req_ready_o[1]=0; one response reg_id=5'b01000 -> one more accept next cycle.
REQ-032 out_ready_i low 5 cycles with out_v_o high: out_packet_o constant, req_ready_o all zero; ready high -> drain, load same cycle.
REQ-033 num_ch_p=2, returned reg_id 5'b10000 with rsp_ready_i[1]=0: rsp_v_o[1]=1, yumi 0; ready high -> yumi 1, outstanding[1] decrements.
REQ-034 num_ch_p=3, returned reg_id 5'b11000: yumi 1, rsp_v_o=0, err_o=1 next cycle and held.
REQ-035 reset_n_i low mid-cycle while out_v_o=1: out_v_o=0 immediately; after release, request on channel 2 -> out_v_o=1 one cycle later.
